// File: rtl/cla_seq_adder.sv
// Sequential add/sub: one CHUNK-bit carry-lookahead slice per cycle, done N=WIDTH/CHUNK edges after start is accepted.
// start is taken only in IDLE and never queued while busy; define CLA_SEQ_ADDER_SAT_EN to saturate sum on signed overflow.
module cla_seq_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int N    = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  generate
    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("cla_seq_adder: WIDTH must be a positive integer multiple of CHUNK");
    end
  endgenerate

  logic [0:0]       state;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] partial;
  logic             carry;

  logic [CHUNK-1:0] a_s;
  logic [CHUNK-1:0] b_s;
  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [CHUNK-1:0] sum_s;
  logic [CHUNK:0]   c;
  logic [WIDTH-1:0] partial_nxt;
  logic [WIDTH-1:0] result;
  logic             ovf_nxt;
  logic             last;
  int               base;

  // Lookahead group for the current slice; c[CHUNK] is the group carry-out.
  always_comb begin
    base = int'(idx) * CHUNK;
    a_s  = a_q[base +: CHUNK];
    b_s  = b_q[base +: CHUNK];
    g    = a_s & b_s;
    p    = a_s ^ b_s;
    c    = '0;
    c[0] = carry;
    for (int i = 0; i < CHUNK; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum_s       = p ^ c[CHUNK-1:0];
    partial_nxt = partial;
    partial_nxt[base +: CHUNK] = sum_s;
    // Only meaningful on the last slice, where c[CHUNK-1] is the carry into the result MSB.
    ovf_nxt = c[CHUNK] ^ c[CHUNK-1];
    last    = (idx == IDXW'(N - 1));
  end

  always_comb begin
    result = partial_nxt;
`ifdef CLA_SEQ_ADDER_SAT_EN
    if (ovf_nxt) begin
      result = partial_nxt[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      partial  <= '0;
      carry    <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry   <= sub ? 1'b1 : cin;
            idx     <= '0;
            partial <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        default: begin
          partial <= partial_nxt;
          carry   <= c[CHUNK];
          idx     <= idx + IDXW'(1);
          if (last) begin
            sum      <= result;
            cout     <= c[CHUNK];
            overflow <= ovf_nxt;
            done     <= 1'b1;
            busy     <= 1'b0;
            idx      <= '0;
            state    <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder: full-width reference model feeds a result queue, popped on each done pulse.
module tb_cla_seq_adder;
  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             cin   = 1'b0;
  logic             sub   = 1'b0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  // Entry layout: {overflow, cout, sum}
  logic [WIDTH+1:0] exp_q[$];
  logic [WIDTH+1:0] last_exp = '0;

  always #5 clk = ~clk;

  cla_seq_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .sum(sum), .cout(cout), .overflow(overflow), .busy(busy), .done(done)
  );

  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic ci, input logic s);
    logic [WIDTH-1:0] be;
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] r;
    logic             ov;
    be   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, be} + {{WIDTH{1'b0}}, (s ? 1'b1 : ci)};
    r    = full[WIDTH-1:0];
    ov   = (x[WIDTH-1] == be[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
`ifdef CLA_SEQ_ADDER_SAT_EN
    if (ov) r = r[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`endif
    return {ov, full[WIDTH], r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic ci, input logic s);
    a = x; b = y; cin = ci; sub = s; start = 1'b1;
    tick();
    start = 1'b0;
    exp_q.push_back(model(x, y, ci, s));
  endtask

  // lat0 = edges already elapsed since the accepting edge
  task automatic wait_result(input string tag, input int lat0);
    int lat;
    logic [WIDTH+1:0] e;
    lat = lat0;
    check({tag, "/busy_run"}, {31'b0, busy}, 32'd1);
    while (!done && lat < 4 * N + 8) begin
      tick();
      lat++;
      if (!done) begin
        check({tag, "/busy_hold"}, {31'b0, busy}, 32'd1);
        check({tag, "/sum_stable"}, {16'b0, sum}, {16'b0, last_exp[WIDTH-1:0]});
      end
    end
    check({tag, "/done"}, {31'b0, done}, 32'd1);
    check({tag, "/latency"}, lat, N);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    check({tag, "/sum"}, {16'b0, sum}, {16'b0, e[WIDTH-1:0]});
    check({tag, "/cout"}, {31'b0, cout}, {31'b0, e[WIDTH]});
    check({tag, "/overflow"}, {31'b0, overflow}, {31'b0, e[WIDTH+1]});
    check({tag, "/busy_end"}, {31'b0, busy}, 32'd0);
    last_exp = e;
  endtask

  task automatic count_dones(input string tag, input int cycles);
    int n;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done) n++;
    end
    check(tag, n, 0);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst/sum", {16'b0, sum}, 32'd0);
    check("rst/cout", {31'b0, cout}, 32'd0);
    check("rst/overflow", {31'b0, overflow}, 32'd0);
    check("rst/busy", {31'b0, busy}, 32'd0);
    check("rst/done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;
    tick();

    accept(16'h00FF, 16'h0001, 1'b0, 1'b0);
    wait_result("add", 0);
    tick();
    check("add/done_one_cycle", {31'b0, done}, 32'd0);

    accept(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_result("wrap_cin0", 0);
    accept(16'hFFFF, 16'h0001, 1'b1, 1'b0);
    wait_result("wrap_cin1", 0);

    accept(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_result("ovf_pos", 0);
    accept(16'h8000, 16'hFFFF, 1'b0, 1'b0);
    wait_result("ovf_neg", 0);

    accept(16'h0005, 16'h0007, 1'b1, 1'b1);
    wait_result("sub_borrow", 0);
    accept(16'h0009, 16'h0002, 1'b0, 1'b1);
    wait_result("sub_pos", 0);
    accept(16'h8000, 16'h0001, 1'b0, 1'b1);
    wait_result("sub_ovf", 0);

    // start while busy is ignored; operand bus changes after acceptance
    accept(16'h1234, 16'h1111, 1'b0, 1'b0);
    tick();
    tick();
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_result("ignore_busy", 3);
    count_dones("ignore_busy/extra_done", 6);
    check("ignore_busy/idle", {31'b0, busy}, 32'd0);

    // start during the done cycle is accepted
    accept(16'h0F0F, 16'h00F1, 1'b1, 1'b0);
    wait_result("b2b_first", 0);
    accept(16'h4000, 16'h4000, 1'b0, 1'b0);
    wait_result("b2b_second", 0);

    for (int i = 0; i < 6; i++) begin
      accept(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
      wait_result("random", 0);
    end

    // Asynchronous reset mid-operation
    accept(16'h1357, 16'h2468, 1'b0, 1'b0);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst/sum", {16'b0, sum}, 32'd0);
    check("midrst/cout", {31'b0, cout}, 32'd0);
    check("midrst/overflow", {31'b0, overflow}, 32'd0);
    check("midrst/busy", {31'b0, busy}, 32'd0);
    check("midrst/done", {31'b0, done}, 32'd0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    last_exp = '0;
    tick();
    #3 rst_n = 1'b1;
    count_dones("midrst/no_done", 8);
    accept(16'h0001, 16'h0002, 1'b1, 1'b0);
    wait_result("after_rst", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
